// File: rtl/sum_accumulator_if.sv
// Purpose: groups the sample-in and result-out handshakes of sum_accumulator
//   into one bundle.
// Signals:
//   clear         - synchronous block abort (producer side)
//   data_in       - unsigned sample
//   data_valid    - data_in holds a sample
//   data_ready    - accumulator can take a sample this cycle
//   result        - registered block total
//   result_valid  - result holds a complete block
//   result_ready  - consumer takes the result this cycle
//   overflow_flag - sticky carry-out seen in the current block
//   count         - samples accepted in the current block
// Handshake: a transfer happens on a rising clk edge where both valid and
//   ready are 1. Valid never depends on ready, and the accumulator's ready
//   and valid outputs come straight from registers.
interface sum_accumulator_if #(
   parameter int BIT_WIDTH = 8
);
   logic                 clear;
   logic [BIT_WIDTH-1:0] data_in;
   logic                 data_valid;
   logic                 data_ready;
   logic [BIT_WIDTH-1:0] result;
   logic                 result_valid;
   logic                 result_ready;
   logic                 overflow_flag;
   logic [7:0]           count;

   modport master (
      output clear, data_in, data_valid, result_ready,
      input  data_ready, result, result_valid, overflow_flag, count
   );

   modport slave (
      input  clear, data_in, data_valid, result_ready,
      output data_ready, result, result_valid, overflow_flag, count
   );
endinterface

// File: rtl/sum_accumulator.sv
// Purpose: accumulates NUM_SAMPLES unsigned samples into a running total
//   (modulo 2^BIT_WIDTH) using one adder_nbit, then holds the total and a
//   sticky overflow flag until the consumer takes it.
// Ports:
//   clk       - system clock, rising edge
//   n_rst     - asynchronous active-low reset
//   bus       - sum_accumulator_if.slave (sample in, result out, clear)
//   dbg_state - current FSM state (0 = ACCUM, 1 = HOLD)

// Plain ripple adder: {overflow, sum} = a + b + carry_in.
module adder_nbit #(
   parameter int BIT_WIDTH = 8
) (
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 carry_in,
   output logic [BIT_WIDTH-1:0] sum,
   output logic                 overflow
);
   assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};
endmodule

module sum_accumulator #(
   parameter int BIT_WIDTH   = 8,
   parameter int NUM_SAMPLES = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   sum_accumulator_if.slave        bus,
   output logic                    dbg_state
);
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(NUM_SAMPLES - 1);

   state_t               state_q, state_d;
   logic [BIT_WIDTH-1:0] acc_q, acc_d;
   logic [7:0]           count_q, count_d;
   logic                 ovf_q, ovf_d;

   logic [BIT_WIDTH-1:0] add_sum;
   logic                 add_carry;

   adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_adder (
      .a        (acc_q),
      .b        (bus.data_in),
      .carry_in (1'b0),
      .sum      (add_sum),
      .overflow (add_carry)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      // clear wins over any accept or result handshake in the same cycle
      if (bus.clear) begin
         state_d = ACCUM;
         acc_d   = '0;
         count_d = '0;
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (bus.data_valid) begin
                  acc_d   = add_sum;
                  ovf_d   = ovf_q | add_carry;
                  count_d = count_q + 8'd1;
                  if (count_q == LAST_IDX) state_d = HOLD;
               end
            end
            HOLD: begin
               if (bus.result_ready) begin
                  state_d = ACCUM;
                  acc_d   = '0;
                  count_d = '0;
                  ovf_d   = 1'b0;
               end
            end
            default: state_d = ACCUM;
         endcase
      end
   end

   assign bus.data_ready    = (state_q == ACCUM);
   assign bus.result_valid  = (state_q == HOLD);
   assign bus.result        = acc_q;
   assign bus.overflow_flag = ovf_q;
   assign bus.count         = count_q;
   assign dbg_state         = state_q;

`ifndef SYNTHESIS
   a_inputs_known: assert property (@(posedge clk) disable iff (!n_rst)
      !$isunknown(bus.data_in) && !$isunknown(bus.clear))
      else $error("data_in or clear is X/Z");

   a_hold_stable: assert property (@(posedge clk) disable iff (!n_rst)
      (state_q == HOLD && !bus.result_ready && !bus.clear) |=> $stable(acc_q))
      else $error("result changed while held");

   a_count_range: assert property (@(posedge clk) disable iff (!n_rst)
      count_q <= 8'(NUM_SAMPLES))
      else $error("count exceeded NUM_SAMPLES");
`endif
endmodule
